gfx_shadow_regfile: RTL and testbench

//  Parametrised, double-buffered register bank between the CPU databus and the

---
 rtl/gfx_regfile_pkg.sv | 30 +++
 rtl/gfx_commit_fsm.sv | 61 ++++++
 rtl/gfx_shadow_regfile.sv | 171 +++++++++++++++++
 tb/tb_gfx_shadow_regfile.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_regfile_pkg.sv
// Shared constants and types for the graphics shadow register bank:
// register address map, commit FSM state encoding and CTRL bit positions.
package gfx_regfile_pkg;

    // Register address map of the default 10-register game bank.
    localparam int unsigned PADDLE1_X  = 0;
    localparam int unsigned PADDLE1_Y  = 1;
    localparam int unsigned PADDLE2_X  = 2;
    localparam int unsigned PADDLE2_Y  = 3;
    localparam int unsigned BALL_X     = 4;
    localparam int unsigned BALL_Y     = 5;
    localparam int unsigned BALL_Z     = 6;
    localparam int unsigned P1_SCORE   = 7;
    localparam int unsigned P2_SCORE   = 8;
    localparam int unsigned GAME_STATE = 9;
    localparam int unsigned CTRL_ADDR  = 10;

    // CTRL write: bit that requests an armed commit.
    localparam int unsigned CTRL_ARM_BIT   = 0;
    // CTRL read: bit positions of the status word.
    localparam int unsigned CTRL_MODE_BIT  = 0;
    localparam int unsigned CTRL_ARMED_BIT = 1;

    // Commit FSM states. ARMED means the next frame_end copies buffer to shadow.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_e;

endpackage

// File: rtl/gfx_commit_fsm.sv
// Commit controller for the shadow register bank.
// COMMIT_MODE=0: every frame_end produces a latch enable; the FSM idles.
// COMMIT_MODE=1: a CTRL arm moves IDLE->ARMED; the next frame_end latches
// and returns to IDLE, unless a fresh arm arrives on that same edge, in
// which case the latch still happens and the FSM stays ARMED.
module gfx_commit_fsm
    import gfx_regfile_pkg::*;
#(
    parameter int unsigned COMMIT_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm_req,
    input  logic          frame_end,
    output logic          latch_en,
    output commit_state_e state_dbg
);

    commit_state_e state_q;
    commit_state_e state_d;

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and latch enable decode.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        if (COMMIT_MODE == 0) begin
            latch_en = frame_end;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // An arm coinciding with frame_end only arms; no latch yet.
                    if (arm_req) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    latch_en = frame_end;
                    if (frame_end && !arm_req) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule

// File: rtl/gfx_shadow_regfile.sv
// Double-buffered register bank between the CPU databus and the renderers.
// The CPU reads and writes the buffer; renderers only see the shadow copy,
// which is refreshed from the buffer at frame end (optionally only when armed).
//
// Bus handshake: a transaction is one cycle with cs=1, sampled at a rising
// edge N; rd selects read (1) or write (0). Writes take databus at edge N.
// Every transaction, in range or not, is answered with ack=1 during cycle
// N+1. A read additionally drives databus for exactly that cycle. A new
// transaction may be presented in every cycle; there is no stall.
module gfx_shadow_regfile
    import gfx_regfile_pkg::*;
#(
    parameter int unsigned                 DATA_W      = 16,
    parameter int unsigned                 NUM_REGS    = 10,
    parameter int unsigned                 ADDR_W      = 4,
    parameter int unsigned                 COMMIT_MODE = 0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          addr,
    inout  wire logic [DATA_W-1:0]     databus,
    output logic                       ack,
    input  logic                       frame_end,
    output logic [NUM_REGS*DATA_W-1:0] shadow_flat,
    output logic                       latched,
    output logic [NUM_REGS-1:0]        dirty
);

    // The CTRL register sits right after the last game register.
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0]   buffer_q [NUM_REGS];
    logic [DATA_W-1:0]   buffer_d [NUM_REGS];
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;
    logic [NUM_REGS-1:0] dirty_d;
    logic                ack_q;
    logic                ack_d;
    logic                latched_q;
    logic                latched_d;
    logic                oe_q;
    logic                oe_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rdata_d;

    logic                rd_req;
    logic                wr_req;
    logic                in_range;
    logic                is_ctrl;
    logic                arm_req;
    logic                latch_en;
    logic                armed;
    logic                bus_oe;
    commit_state_e       commit_state;

    assign rd_req   = cs & rd;
    assign wr_req   = cs & ~rd;
    assign in_range = (addr < CTRL_A);
    assign is_ctrl  = (addr == CTRL_A);
    assign arm_req  = wr_req & is_ctrl & databus[CTRL_ARM_BIT];
    assign armed    = (commit_state == ST_ARMED);

    gfx_commit_fsm #(
        .COMMIT_MODE (COMMIT_MODE)
    ) u_commit_fsm (
        .clk       (clk),
        .rst       (rst),
        .arm_req   (arm_req),
        .frame_end (frame_end),
        .latch_en  (latch_en),
        .state_dbg (commit_state)
    );

    // Buffer update: a write to an in-range address replaces that register.
    always_comb begin
        buffer_d = buffer_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_req && in_range && (addr == ADDR_W'(i))) begin
                buffer_d[i] = databus;
            end
        end
    end

    // Shadow copy: takes the pre-write buffer contents on a latch edge.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (latch_en) begin
                shadow_d[i] = buffer_q[i];
            end
        end
    end

    // Dirty tracking: latch clears all bits, a same-edge write sets its bit again.
    always_comb begin
        dirty_d = dirty_q;
        if (latch_en) begin
            dirty_d = '0;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_req && in_range && (addr == ADDR_W'(i))) begin
                dirty_d[i] = 1'b1;
            end
        end
    end

    // Read response data and registered output enable, plus ack/latched pulses.
    always_comb begin
        rdata_d   = '0;
        oe_d      = rd_req;
        ack_d     = cs;
        latched_d = latch_en;
        if (rd_req) begin
            if (is_ctrl) begin
                rdata_d[CTRL_ARMED_BIT] = armed;
                rdata_d[CTRL_MODE_BIT]  = (COMMIT_MODE != 0);
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr == ADDR_W'(i)) begin
                        rdata_d = buffer_q[i];
                    end
                end
            end
        end
    end

    // Register state; reset reloads both banks from RESET_VALS and drops any response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                buffer_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
                shadow_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
            dirty_q   <= '0;
            ack_q     <= 1'b0;
            latched_q <= 1'b0;
            oe_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            buffer_q  <= buffer_d;
            shadow_q  <= shadow_d;
            dirty_q   <= dirty_d;
            ack_q     <= ack_d;
            latched_q <= latched_d;
            oe_q      <= oe_d;
            rdata_q   <= rdata_d;
        end
    end

    // Flatten the shadow bank for the renderers.
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_flat[i*DATA_W +: DATA_W] = shadow_q[i];
        end
    end

    // The enable is registered; a write presented in the response cycle
    // still wins the bus so the CPU's write data is never fought.
    assign bus_oe  = oe_q & ~wr_req;
    assign databus = bus_oe ? rdata_q : 'z;

    assign ack     = ack_q;
    assign latched = latched_q;
    assign dirty   = dirty_q;

endmodule

// File: tb/tb_gfx_shadow_regfile.sv
// Bench for gfx_shadow_regfile: one instance per commit mode, driven with the
// same bus/frame stimulus and checked against a per-mode reference model.
module tb_gfx_shadow_regfile;

    localparam int DW = 16;
    localparam int NR = 10;
    localparam int AW = 4;
    localparam int CTRL = NR;

    localparam logic [NR*DW-1:0] RV_FLAT = {16'd0, 16'd0, 16'd0, 16'd0, 16'd240,
                                            16'd320, 16'd240, 16'd320, 16'd240, 16'd320};
    localparam logic [DW-1:0] RV_TAB [NR] = '{16'd320, 16'd240, 16'd320, 16'd240, 16'd320,
                                              16'd240, 16'd0, 16'd0, 16'd0, 16'd0};

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          rd = 1'b0;
    logic          frame_end = 1'b0;
    logic          tb_drv = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    tri1 [DW-1:0] bus0;
    tri1 [DW-1:0] bus1;
    assign bus0 = tb_drv ? wdata : 'z;
    assign bus1 = tb_drv ? wdata : 'z;

    logic             ack_w     [2];
    logic             latched_w [2];
    logic [NR-1:0]    dirty_w   [2];
    logic [NR*DW-1:0] shadow_w  [2];

    gfx_shadow_regfile #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .COMMIT_MODE(0), .RESET_VALS(RV_FLAT)
    ) u_dut0 (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .addr(addr), .databus(bus0),
        .ack(ack_w[0]), .frame_end(frame_end), .shadow_flat(shadow_w[0]),
        .latched(latched_w[0]), .dirty(dirty_w[0])
    );

    gfx_shadow_regfile #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .COMMIT_MODE(1), .RESET_VALS(RV_FLAT)
    ) u_dut1 (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .addr(addr), .databus(bus1),
        .ack(ack_w[1]), .frame_end(frame_end), .shadow_flat(shadow_w[1]),
        .latched(latched_w[1]), .dirty(dirty_w[1])
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_buf    [2][NR];
    logic [DW-1:0] m_shadow [2][NR];
    logic [NR-1:0] m_dirty  [2];
    logic          m_armed  [2];
    logic          m_ack    [2];
    logic          m_latched[2];
    logic          model_ok = 1'b0;
    // Expected read responses, pushed as (mode0, mode1) pairs.
    logic [DW-1:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] shadow_of(input int m);
        logic [NR*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_shadow[m][i];
        return f;
    endfunction

    // Apply the rules of one clock edge to the model.
    task automatic model_edge(input logic i_cs, input logic i_rd, input int a,
                              input logic [DW-1:0] wd, input logic fe, input logic r);
        logic          do_latch;
        logic          pre_armed;
        logic [DW-1:0] resp;
        if (r) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < NR; i++) begin
                    m_buf[m][i]    = RV_TAB[i];
                    m_shadow[m][i] = RV_TAB[i];
                end
                m_dirty[m] = '0; m_armed[m] = 1'b0; m_ack[m] = 1'b0; m_latched[m] = 1'b0;
            end
            exp_q.delete();
            model_ok = 1'b1;
            return;
        end
        for (int m = 0; m < 2; m++) begin
            pre_armed = m_armed[m];
            do_latch  = fe && (m == 0 || pre_armed);
            if (i_cs && i_rd) begin
                if (a < NR) resp = m_buf[m][a];
                else if (a == CTRL) resp = DW'(2 * int'(pre_armed) + m);
                else resp = '0;
                exp_q.push_back(resp);
            end
            if (do_latch) begin
                for (int i = 0; i < NR; i++) m_shadow[m][i] = m_buf[m][i];
                m_dirty[m] = '0;
            end
            m_latched[m] = do_latch;
            if (m == 1) m_armed[m] = (i_cs && !i_rd && a == CTRL && wd[0]) || (pre_armed && !do_latch);
            if (i_cs && !i_rd && a < NR) begin
                m_buf[m][a] = wd;
                m_dirty[m][a] = 1'b1;
            end
            m_ack[m] = i_cs;
        end
    endtask

    // ---------------- driver ----------------
    // One bus cycle: present inputs, check the bus, clock, check registered outputs.
    task automatic step(input logic i_cs, input logic i_rd, input int a,
                        input logic [DW-1:0] wd, input logic fe, input logic r);
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        cs = i_cs; rd = i_rd; addr = AW'(a); wdata = wd; frame_end = fe; rst = r;
        tb_drv = i_cs && !i_rd;
        #1;
        e0 = '1; e1 = '1;
        if (exp_q.size() >= 2) begin
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
        end
        if (model_ok && !tb_drv) begin
            chk("bus0", NR*DW'(bus0), NR*DW'(e0));
            chk("bus1", NR*DW'(bus1), NR*DW'(e1));
        end
        @(posedge clk);
        model_edge(i_cs, i_rd, a, wd, fe, r);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ack%0d", m), NR*DW'(ack_w[m]), NR*DW'(m_ack[m]));
            chk($sformatf("latched%0d", m), NR*DW'(latched_w[m]), NR*DW'(m_latched[m]));
            chk($sformatf("dirty%0d", m), NR*DW'(dirty_w[m]), NR*DW'(m_dirty[m]));
            chk($sformatf("shadow%0d", m), shadow_w[m], shadow_of(m));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic fe);
        step(1'b1, 1'b0, a, d, fe, 1'b0);
    endtask

    task automatic rd_op(input int a);
        step(1'b1, 1'b1, a, '0, 1'b0, 1'b0);
    endtask

    task automatic fe_pulse();
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        // Reset: shadow at reset values, dirty/ack/latched clear, bus released.
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        idle(2);

        // Write then read register 0; shadow follows only at frame end.
        wr(0, 16'h0155, 1'b0);
        rd_op(0);
        idle(2);
        fe_pulse();
        idle(1);
        rd_op(0);

        // Write coinciding with frame_end: shadow keeps old, dirty survives.
        wr(4, 16'd77, 1'b1);
        idle(1);
        fe_pulse();
        idle(1);

        // Commit gating: no latch in mode 1 until armed.
        for (int i = 0; i < 4; i++) wr(i, DW'(16'h1000 + i), 1'b0);
        fe_pulse();
        idle(1);
        fe_pulse();
        rd_op(CTRL);
        wr(CTRL, 16'h0001, 1'b0);
        rd_op(CTRL);
        fe_pulse();
        rd_op(CTRL);
        idle(1);

        // Arm together with frame_end while idle, then again while armed.
        wr(CTRL, 16'h0001, 1'b1);
        rd_op(CTRL);
        wr(5, 16'h0aaa, 1'b0);
        wr(CTRL, 16'h0001, 1'b1);
        rd_op(CTRL);
        fe_pulse();
        rd_op(CTRL);
        // Arm with bit0 clear does nothing.
        wr(CTRL, 16'hfffe, 1'b0);
        rd_op(CTRL);

        // Out-of-range accesses.
        rd_op(15);
        wr(12, 16'hbeef, 1'b0);
        rd_op(11);
        idle(1);

        // Back-to-back read then write: the write owns the bus.
        rd_op(2);
        wr(2, 16'h2222, 1'b0);
        rd_op(2);
        idle(1);

        // Reset during a read response.
        rd_op(4);
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            logic          r_cs;
            logic          r_rd;
            int            r_a;
            logic [DW-1:0] r_d;
            logic          r_fe;
            logic          r_rst;
            r_cs  = ($urandom_range(0, 9) < 7);
            r_rd  = $urandom_range(0, 1);
            r_a   = ($urandom_range(0, 5) == 0) ? CTRL : $urandom_range(0, 15);
            r_d   = DW'($urandom);
            r_fe  = ($urandom_range(0, 5) == 0);
            r_rst = ($urandom_range(0, 199) == 0);
            step(r_cs, r_rd, r_a, r_d, r_fe, r_rst);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
